// File: rtl/coffee_pkg.sv
// -----------------------------------------------------------------------------
// coffee_pkg
// Shared constants and types for the coffee machine coin paths.
//  - Coin values (in currency units), reused by the acceptance counters.
//  - Default change-amount width and the 500-coin value in 100-units.
//  - State encoding of the change dispenser FSM.
//  - Small helper for sizing counters.
// -----------------------------------------------------------------------------
package coffee_pkg;

    // Face values of the two coin types handled by the machine
    localparam int COIN_VALUE_100 = 100;
    localparam int COIN_VALUE_500 = 500;

    // Change is tracked in 100-units; 4 bits covers up to 1500
    localparam int DISP_AMOUNT_W = 4;

    // One 500 coin expressed in 100-units
    localparam int DISP_UNIT_500 = COIN_VALUE_500 / COIN_VALUE_100;

    // Dispenser FSM states; explicit codes keep traces stable across builds
    typedef enum logic [2:0] {
        DISP_IDLE      = 3'd0,
        DISP_SELECT    = 3'd1,
        DISP_PULSE_500 = 3'd2,
        DISP_PULSE_100 = 3'd3,
        DISP_GAP       = 3'd4,
        DISP_DONE      = 3'd5,
        DISP_FAULT     = 3'd6
    } disp_state_t;

    // Larger of two integers, used for elaboration-time sizing
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cycle_counter_module.sv
// -----------------------------------------------------------------------------
// cycle_counter_module
// Loadable down-counter with a zero flag. Used by the dispenser to time both
// the ejector pulse and the gap that follows it.
//
// Ports:
//   clock       in   system clock
//   reset       in   synchronous, active-high reset (count -> 0)
//   load        in   load load_value this cycle (takes priority)
//   load_value  in   WIDTH  value to load; interval length minus one
//   decrement   in   count down by one (holds at zero)
//   is_zero     out  count is currently zero
// -----------------------------------------------------------------------------
module cycle_counter_module #(
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             decrement,
    output logic             is_zero
);

    logic [WIDTH-1:0] count_r;

    // Down-counter: load wins over decrement, and it never wraps below zero
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_value;
        end else if (decrement && (count_r != '0)) begin
            count_r <= count_r - WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign is_zero = (count_r == '0);

endmodule

// File: rtl/change_dispenser_module.sv
// -----------------------------------------------------------------------------
// change_dispenser_module
// Pays out change greedily (500 coins first, then 100 coins) as timed ejector
// pulses, and reports busy / done / fault to the machine FSM.
//
// Ports:
//   clock           in   system clock
//   reset           in   synchronous, active-high reset
//   start           in   request payout; only honoured in IDLE
//   change_amount   in   AMOUNT_W  change owed in 100-units, sampled with start
//   tube_500_empty  in   500-coin tube empty (looked at only in SELECT)
//   tube_100_empty  in   100-coin tube empty (looked at only in SELECT)
//   coin_500_out    out  500-coin ejector pulse
//   coin_100_out    out  100-coin ejector pulse
//   busy            out  high whenever the FSM is not IDLE
//   done            out  one-cycle pulse when the payout completed
//   fault           out  sticky; payout could not complete
//   remaining       out  AMOUNT_W  change still owed
//
// Per-coin period is 1 (SELECT) + PULSE_CYCLES + GAP_CYCLES cycles.
// -----------------------------------------------------------------------------
module change_dispenser_module
    import coffee_pkg::*;
#(
    parameter int AMOUNT_W     = DISP_AMOUNT_W,
    parameter int UNIT_500     = DISP_UNIT_500,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [AMOUNT_W-1:0] change_amount,
    input  logic                tube_500_empty,
    input  logic                tube_100_empty,
    output logic                coin_500_out,
    output logic                coin_100_out,
    output logic                busy,
    output logic                done,
    output logic                fault,
    output logic [AMOUNT_W-1:0] remaining
);

    // Counter holds interval-minus-one, so its width must cover the longer one
    localparam int CNT_MAX = max_int(PULSE_CYCLES, GAP_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0]    PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [AMOUNT_W-1:0] UNIT_500_L = AMOUNT_W'(UNIT_500);
    localparam logic [AMOUNT_W-1:0] UNIT_100_L = AMOUNT_W'(1);

    disp_state_t         state_r;
    disp_state_t         state_next_s;
    logic [AMOUNT_W-1:0] remaining_r;
    logic [AMOUNT_W-1:0] remaining_next_s;
    logic                fault_r;
    logic                fault_next_s;
    logic                busy_r;
    logic                done_r;
    logic                coin_500_r;
    logic                coin_100_r;

    logic                ctr_load_s;
    logic [CNT_W-1:0]    ctr_load_value_s;
    logic                ctr_dec_s;
    logic                ctr_zero_s;

    // Interval timer shared by the pulse and gap phases
    cycle_counter_module #(
        .WIDTH (CNT_W)
    ) u_cycle_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (ctr_load_s),
        .load_value (ctr_load_value_s),
        .decrement  (ctr_dec_s),
        .is_zero    (ctr_zero_s)
    );

    // Next-state, owed-amount and fault decisions; the counter is reloaded on
    // every phase entry so each phase times itself from a known value
    always_comb begin
        state_next_s     = state_r;
        remaining_next_s = remaining_r;
        fault_next_s     = fault_r;
        ctr_load_s       = 1'b0;
        ctr_load_value_s = '0;
        ctr_dec_s        = 1'b0;

        case (state_r)
            DISP_IDLE: begin
                if (start) begin
                    state_next_s     = DISP_SELECT;
                    remaining_next_s = change_amount;
                    fault_next_s     = 1'b0;
                end else begin
                    state_next_s = DISP_IDLE;
                end
            end

            DISP_SELECT: begin
                if (remaining_r == '0) begin
                    state_next_s = DISP_DONE;
                end else if ((remaining_r >= UNIT_500_L) && !tube_500_empty) begin
                    state_next_s     = DISP_PULSE_500;
                    ctr_load_s       = 1'b1;
                    ctr_load_value_s = PULSE_LOAD;
                end else if ((remaining_r >= UNIT_100_L) && !tube_100_empty) begin
                    // Also the fallback when the 500 tube has run dry
                    state_next_s     = DISP_PULSE_100;
                    ctr_load_s       = 1'b1;
                    ctr_load_value_s = PULSE_LOAD;
                end else begin
                    state_next_s = DISP_FAULT;
                    fault_next_s = 1'b1;
                end
            end

            DISP_PULSE_500: begin
                if (ctr_zero_s) begin
                    // SELECT already guaranteed remaining >= UNIT_500
                    state_next_s     = DISP_GAP;
                    remaining_next_s = remaining_r - UNIT_500_L;
                    ctr_load_s       = 1'b1;
                    ctr_load_value_s = GAP_LOAD;
                end else begin
                    ctr_dec_s = 1'b1;
                end
            end

            DISP_PULSE_100: begin
                if (ctr_zero_s) begin
                    // SELECT already guaranteed remaining >= 1
                    state_next_s     = DISP_GAP;
                    remaining_next_s = remaining_r - UNIT_100_L;
                    ctr_load_s       = 1'b1;
                    ctr_load_value_s = GAP_LOAD;
                end else begin
                    ctr_dec_s = 1'b1;
                end
            end

            DISP_GAP: begin
                if (ctr_zero_s) begin
                    state_next_s = DISP_SELECT;
                end else begin
                    ctr_dec_s = 1'b1;
                end
            end

            DISP_DONE: begin
                state_next_s = DISP_IDLE;
            end

            DISP_FAULT: begin
                state_next_s = DISP_IDLE;
            end

            default: begin
                state_next_s = DISP_IDLE;
            end
        endcase
    end

    // State, datapath and outputs; outputs are decoded from the next state so
    // they line up with the state they describe while still coming from flops
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= DISP_IDLE;
            remaining_r <= '0;
            fault_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            coin_500_r  <= 1'b0;
            coin_100_r  <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            remaining_r <= remaining_next_s;
            fault_r     <= fault_next_s;
            busy_r      <= (state_next_s != DISP_IDLE);
            done_r      <= (state_next_s == DISP_DONE);
            coin_500_r  <= (state_next_s == DISP_PULSE_500);
            coin_100_r  <= (state_next_s == DISP_PULSE_100);
        end
    end

    assign coin_500_out = coin_500_r;
    assign coin_100_out = coin_100_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign fault        = fault_r;
    assign remaining    = remaining_r;

endmodule

// File: tb/tb_change_dispenser_module.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser_module
// Self-checking bench for change_dispenser_module with default parameters.
// Expected traces come from a coin-list model: the greedy payout is worked out
// up front as a list of coins, and each cycle's outputs are derived from the
// position inside the 5-cycle coin period.
// -----------------------------------------------------------------------------
module tb_change_dispenser_module;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] change_amount;
    logic       tube_500_empty;
    logic       tube_100_empty;
    logic       coin_500_out;
    logic       coin_100_out;
    logic       busy;
    logic       done;
    logic       fault;
    logic [3:0] remaining;

    int tests = 0;
    int fails = 0;

    change_dispenser_module dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .change_amount  (change_amount),
        .tube_500_empty (tube_500_empty),
        .tube_100_empty (tube_100_empty),
        .coin_500_out   (coin_500_out),
        .coin_100_out   (coin_100_out),
        .busy           (busy),
        .done           (done),
        .fault          (fault),
        .remaining      (remaining)
    );

    always #5 clock = ~clock;

    typedef struct {
        int amount;
        bit e500;
        bit e100;
        int n500;
        int n100;
        bit flt;
        int rem;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [8:0] out_vec();
        return {coin_500_out, coin_100_out, busy, done, fault, remaining};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One payout with static tube flags, checked every cycle against the model.
    // spam=1 keeps toggling start/change_amount while busy.
    task automatic run_payout(input int amount, input bit e500, input bit e100, input bit spam,
                              output int n500, output int n100, output bit f_end, output int rem_end);
        int   coins[$];
        int   rem;
        int   ncoin;
        int   k;
        int   ph;
        int   owed;
        logic p5;
        logic p1;
        logic rz;
        logic [8:0] exp_v;

        rem = amount;
        while (rem >= 5 && !e500) begin coins.push_back(5); rem -= 5; end
        while (rem >= 1 && !e100) begin coins.push_back(1); rem -= 1; end
        ncoin = coins.size();
        rz = (rem == 0);
        n500 = 0;
        n100 = 0;

        @(negedge clock);
        tube_500_empty = e500;
        tube_100_empty = e100;
        change_amount  = 4'(amount);
        start          = 1'b1;
        @(posedge clock);
        #1;
        start         = 1'b0;
        change_amount = 4'($urandom_range(0, 15));

        for (int t = 1; t <= 5 * ncoin + 3; t++) begin
            @(negedge clock);
            if (t <= 5 * ncoin) begin
                k  = (t - 1) / 5;
                ph = (t - 1) % 5;
                owed = amount;
                for (int j = 0; j < k; j++) owed -= coins[j];
                if (ph >= 3) owed -= coins[k];
                p5 = (ph == 1 || ph == 2) && (coins[k] == 5);
                p1 = (ph == 1 || ph == 2) && (coins[k] == 1);
                exp_v = {p5, p1, 1'b1, 1'b0, 1'b0, 4'(owed)};
            end else if (t == 5 * ncoin + 1) begin
                exp_v = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'(rem)};
            end else if (t == 5 * ncoin + 2) begin
                exp_v = {1'b0, 1'b0, 1'b1, rz, ~rz, 4'(rem)};
            end else begin
                exp_v = {1'b0, 1'b0, 1'b0, 1'b0, ~rz, 4'(rem)};
            end
            check($sformatf("trace amt%0d e5=%0d e1=%0d t%0d", amount, e500, e100, t),
                  32'(out_vec()), 32'(exp_v));
            n500 += int'(coin_500_out);
            n100 += int'(coin_100_out);
            if (spam && (t < 5 * ncoin + 3)) begin
                start         = 1'($urandom_range(0, 1));
                change_amount = 4'($urandom_range(0, 15));
            end else begin
                start = 1'b0;
            end
        end
        f_end   = fault;
        rem_end = int'(remaining);
        n500    = n500 / 2;
        n100    = n100 / 2;
    endtask

    initial begin
        int n5;
        int n1;
        bit f;
        int r;
        int amt;
        bit e5;
        bit e1;
        bit sp;
        logic stray;

        reset          = 1'b1;
        start          = 1'b0;
        change_amount  = 4'd0;
        tube_500_empty = 1'b0;
        tube_100_empty = 1'b0;

        vecs[0] = '{7,  1'b0, 1'b0, 1, 2, 1'b0, 0};
        vecs[1] = '{0,  1'b0, 1'b0, 0, 0, 1'b0, 0};
        vecs[2] = '{10, 1'b1, 1'b0, 0, 10, 1'b0, 0};
        vecs[3] = '{15, 1'b0, 1'b0, 3, 0, 1'b0, 0};
        vecs[4] = '{9,  1'b0, 1'b1, 1, 0, 1'b1, 4};
        vecs[5] = '{3,  1'b0, 1'b1, 0, 0, 1'b1, 3};
        vecs[6] = '{4,  1'b1, 1'b1, 0, 0, 1'b1, 4};
        vecs[7] = '{6,  1'b0, 1'b0, 1, 1, 1'b0, 0};

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_outputs", 32'(out_vec()), 32'd0);
        reset = 1'b0;

        // Table-driven payouts
        for (int i = 0; i < 8; i++) begin
            run_payout(vecs[i].amount, vecs[i].e500, vecs[i].e100, 1'b0, n5, n1, f, r);
            check($sformatf("vec%0d n500", i), n5, vecs[i].n500);
            check($sformatf("vec%0d n100", i), n1, vecs[i].n100);
            check($sformatf("vec%0d fault", i), 32'(f), 32'(vecs[i].flt));
            check($sformatf("vec%0d remaining", i), r, vecs[i].rem);
        end

        // 100 tube runs dry during the 500 pulse of amount 6
        @(negedge clock);
        tube_500_empty = 1'b0;
        tube_100_empty = 1'b0;
        change_amount  = 4'd6;
        start          = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        n1 = 0;
        for (int t = 1; t <= 8; t++) begin
            @(negedge clock);
            n1 += int'(coin_100_out);
            if (t == 2) begin
                check("dry_500_start", 32'(coin_500_out), 32'd1);
                tube_100_empty = 1'b1;
            end else if (t == 3) begin
                check("dry_500_hold", 32'(coin_500_out), 32'd1);
            end else if (t == 4) begin
                check("dry_rem_after_500", 32'({coin_500_out, remaining}), 32'({1'b0, 4'd1}));
            end else if (t == 7) begin
                check("dry_fault_state", 32'({busy, done, fault}), 32'({1'b1, 1'b0, 1'b1}));
            end else if (t == 8) begin
                check("dry_idle_sticky", 32'({busy, fault, remaining}), 32'({1'b0, 1'b1, 4'd1}));
            end else begin
                check($sformatf("dry_no_pulse t%0d", t), 32'({coin_500_out, coin_100_out}), 32'd0);
            end
        end
        check("dry_no_100", n1, 0);
        tube_100_empty = 1'b0;
        run_payout(1, 1'b0, 1'b0, 1'b0, n5, n1, f, r);
        check("refill_fault_cleared", 32'(f), 32'd0);
        check("refill_n100", n1, 1);

        // start hammered while busy must not disturb the trace
        run_payout(7, 1'b0, 1'b0, 1'b1, n5, n1, f, r);
        check("spam_n500", n5, 1);
        check("spam_n100", n1, 2);

        // Reset during the second pulse of amount 2
        @(negedge clock);
        change_amount = 4'd2;
        start         = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (7) @(negedge clock);
        check("rst_mid_pulse_active", 32'(coin_100_out), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_pulse_outputs", 32'(out_vec()), 32'd0);
        reset = 1'b0;
        stray = 1'b0;
        repeat (6) begin
            @(negedge clock);
            stray = stray | busy | done | coin_100_out | coin_500_out;
        end
        check("rst_mid_pulse_quiet", 32'(stray), 32'd0);

        // Randomized payouts against the model
        for (int i = 0; i < 25; i++) begin
            amt = int'($urandom_range(0, 15));
            e5  = ($urandom_range(0, 3) == 0);
            e1  = ($urandom_range(0, 3) == 0);
            sp  = 1'($urandom_range(0, 1));
            run_payout(amt, e5, e1, sp, n5, n1, f, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/change_dispenser_module.md
Name: change_dispenser_module

Overview:
Pays out change from the coffee machine by driving two coin-ejector outputs, one for 100 coins and one for 500 coins. The block sits downstream of the coin/subtraction path. It receives a change amount in units of 100 plus a start strobe. It ejects coins greedily, 500s first, as timed pulses, and reports busy/done/fault back to the machine FSM. It is the payout counterpart of the coin-acceptance counters.

Parameters:
AMOUNT_W, 4, width of change amount and remaining count (units of 100; max 15 = 1500)
UNIT_500, 5, value of one 500 coin in 100-units
PULSE_CYCLES, 2, cycles each ejector pulse is held high (>=1)
GAP_CYCLES, 2, low cycles after every pulse before next decision (>=1)

Ports:
clock  in  1  system clock (slowed machine clock)
reset  in  1  synchronous, active-high reset
start  in  1  request payout; sampled only in IDLE
change_amount  in  AMOUNT_W  change to return, units of 100; sampled with start
tube_500_empty  in  1  500-coin tube empty
tube_100_empty  in  1  100-coin tube empty
coin_500_out  out  1  500-coin ejector pulse
coin_100_out  out  1  100-coin ejector pulse
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse: payout complete
fault  out  1  sticky: payout could not complete
remaining  out  AMOUNT_W  change still owed

Behaviour:
- Reset, synchronous and active-high: state IDLE; all outputs 0; remaining 0. Reset mid-payout aborts at once, and any pulse in progress drops on the next edge.
- All outputs are registered. coin_500_out and coin_100_out are never high in the same cycle.
- States: IDLE, SELECT, PULSE_500, PULSE_100, GAP, DONE, FAULT.
- IDLE: if start=1 at edge N, then at N+1: remaining<=change_amount, fault<=0, state SELECT, busy=1. start is ignored in every other state.
- SELECT (1 cycle) evaluates in priority order:
  - remaining==0 -> DONE.
  - remaining>=UNIT_500 and !tube_500_empty -> PULSE_500.
  - remaining>=1 and !tube_100_empty -> PULSE_100. This branch also applies when remaining>=5 and the 500 tube is empty.
  - Otherwise -> FAULT.
- Tube flags are sampled only in SELECT. A flag changing mid-pulse does not abort the pulse.
- PULSE_x: the matching output is high for exactly PULSE_CYCLES cycles. remaining decrements by UNIT_500 or 1 on the edge that leaves the state. Then go to GAP.
- GAP: outputs low for GAP_CYCLES cycles, then SELECT.
- Per-coin period is 1 + PULSE_CYCLES + GAP_CYCLES cycles: 5 with the defaults.
- Timing with defaults, start at edge N: first pulse high at N+2..N+3, next SELECT at N+6.
- DONE (1 cycle): done=1, busy=1. Next cycle IDLE, busy=0.
- FAULT (1 cycle): fault<=1 (held until next accepted start or reset), busy=1. Next cycle IDLE. remaining keeps the undelivered amount.
- change_amount=0: SELECT at N+1, DONE at N+2, no pulses.
- remaining never underflows; a decrement only happens on a path SELECT has already validated.

Decomposition:
- Shared package coffee_pkg holds:
  - the state enum (disp_state_t);
  - UNIT_500 and default AMOUNT_W;
  - coin-value constants reused by the coin counters.
- One sub-module, cycle_counter_module: loadable down-counter with a zero flag. It times both the PULSE and GAP intervals. Load width is sized to max(PULSE_CYCLES, GAP_CYCLES).

Test Plan:
- reset, start=1 with change_amount=7, tubes full:
  - one coin_500_out pulse, then two coin_100_out pulses;
  - pulses start at N+2, N+7, N+12;
  - remaining steps 7->2->1->0;
  - done=1 at N+17, busy=0 at N+18.
- change_amount=0 -> no pulses, done=1 at N+2, fault=0.
- change_amount=10, tube_500_empty=1 -> ten coin_100_out pulses, done, no coin_500_out.
- change_amount=6, tube_100_empty raised during the 500 pulse:
  - the 500 pulse completes, remaining=1;
  - FAULT follows, then fault=1 sticky, remaining=1, busy=0;
  - the next start with amount 1 and tube refilled clears fault.
- start pulsed repeatedly while busy -> ignored; remaining trace identical to a single start.
- reset asserted during the second pulse of amount 2 -> coin_100_out low and state IDLE on the next edge; remaining=0, no done.
